clk_rst_seq: RTL and testbench
==============================

# clk_rst_seq

Clock/reset sequencer that sits between the board oscillator, the DCM and the design's reset tree. It pulses the DCM reset, waits for a stable lock with timeout and retry, then releases N staged active-high subsystem resets one at a time. It tears everything down again on any loss of lock. It runs on the free-running input clock, never on a DCM output.

## Interface
Parameters:
- N_STAGES, 3: number of staged reset outputs (1..8).
- DCM_RST_CYC, 4: cycles dcm_rst is held high per attempt (≥1).
- LOCK_STABLE, 16: consecutive synchronized-lock cycles required before staging (≥1).
- LOCK_TIMEOUT, 4095: cycles allowed in WAITLOCK before retry (> LOCK_STABLE+2).
- STAGE_DLY, 127: cycles between successive stage releases (≥1).

Ports:
- clk  in  1  free-running oscillator clock; the only clock.
- rst_  in  1  asynchronous, active-low reset.
- lock  in  1  DCM LOCKED, asynchronous to clk; 2-flop synchronized internally to lock_s.
- dcm_rst  out  1  DCM reset, active high.
- rst_out  out  N_STAGES  subsystem resets, active high; bit 0 releases first.
- ready  out  1  high when all stages are released and lock holds.
- retries  out  4  count of lock timeouts, saturating at 15.

## Operation
- States: DCMRST, WAITLOCK, STAGE, RUN. While rst_ is low: state=DCMRST, dcm_rst=1, rst_out=all 1s, ready=0, retries=0, synchronizer flops=0, all counters=0.
- DCMRST: dcm_rst=1, rst_out all 1s. Counter increments each edge. At the edge where the count reaches DCM_RST_CYC, set dcm_rst=0, clear the counters, and go to WAITLOCK.
- WAITLOCK: two counters run.
  - Stable counter: +1 on each edge with lock_s=1; cleared to 0 on any edge with lock_s=0.
  - Timeout counter: +1 on every edge.
  - When stable reaches LOCK_STABLE, go to STAGE and clear the counters.
  - Otherwise, when timeout reaches LOCK_TIMEOUT: go to DCMRST, set dcm_rst=1, and increment retries (saturating).
  - If both happen on the same edge, stable wins.
- STAGE: stage counter +1 per edge. When it reaches STAGE_DLY, clear the lowest still-set rst_out bit and reset the counter. The edge after the last bit clears: go to RUN, ready=1.
- RUN: hold. ready=1, rst_out=0, dcm_rst=0.
- Lock loss: lock_s=0 sampled in STAGE or RUN. On that edge rst_out becomes all 1s, ready=0, dcm_rst=1, and state goes to DCMRST with counters cleared. retries is unchanged; only timeouts count.
- retries is never cleared except by rst_. It keeps counting across successful locks.
- rst_out bits only ever deassert in index order. Any reassertion reasserts all bits together.

## Timing
- Edge numbering: edge 1 is the first rising clk edge after rst_ deasserts.
- lock-to-lock_s latency: 2 edges.
- dcm_rst deasserts at edge DCM_RST_CYC.
- With lock_s already high on entry, STAGE is entered at edge DCM_RST_CYC+LOCK_STABLE.
- rst_out[k] clears (k+1)·STAGE_DLY edges after STAGE entry.
- ready rises 1 edge after rst_out[N_STAGES-1] clears.
- Lock-loss response is 1 edge after lock_s falls, i.e. 3 edges after lock falls.
- An asynchronous rst_ assertion forces reset values immediately, mid-operation, in any state.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Settings for all scenarios: N_STAGES=3, DCM_RST_CYC=4, LOCK_STABLE=4, LOCK_TIMEOUT=32, STAGE_DLY=8.
- Normal bring-up: lock=1 throughout, release rst_ -> dcm_rst falls at edge 4, STAGE entered at edge 8, rst_out 111→110 at edge 16, →100 at 24, →000 at 32, ready=1 at 33, retries=0.
- Lock never asserts -> WAITLOCK entered at edge 4, timeout at edge 36, dcm_rst high edges 36–40, retries=1; retries reaches 15 after 15 timeouts and stays at 15 after the 16th.
- Glitchy lock: lock high 3 cycles, low 1, then high -> stable counter restarts; STAGE entry is delayed accordingly; no rst_out change before 4 consecutive lock_s cycles.
- Lock drop in RUN: deassert lock at edge 50 -> rst_out=111, ready=0, dcm_rst=1 at edge 53; re-lock repeats the staged sequence; retries unchanged.
- Lock drop mid-STAGE, after rst_out[0] has cleared -> all bits back to 1 together; sequencing restarts from DCMRST.
- rst_ asserted asynchronously while in RUN -> outputs take reset values without a clk edge (dcm_rst=1, rst_out=111, ready=0, retries=0).

Source files
------------

// File: rtl/clk_rst_seq.sv
// -----------------------------------------------------------------------------
// clk_rst_seq
//
// Clock/reset sequencer placed between the board oscillator, the DCM and the
// design's reset tree. Runs only on the free-running oscillator clock.
//
// Sequence: pulse the DCM reset, wait for LOCKED to stay high for LOCK_STABLE
// consecutive cycles (retrying with a fresh DCM reset on timeout), then release
// N_STAGES active-high subsystem resets one at a time, bit 0 first. Any loss of
// lock while staging or running reasserts every reset and starts over.
//
// Ports:
//   clk      in   1         free-running oscillator clock
//   rst_     in   1         asynchronous active-low reset
//   lock     in   1         DCM LOCKED, asynchronous to clk
//   dcm_rst  out  1         DCM reset, active high
//   rst_out  out  N_STAGES  staged subsystem resets, active high
//   ready    out  1         all stages released and lock holding
//   retries  out  4         lock-timeout count, saturating at 15
// -----------------------------------------------------------------------------
module clk_rst_seq #(
    parameter int N_STAGES     = 3,
    parameter int DCM_RST_CYC  = 4,
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 4095,
    parameter int STAGE_DLY    = 127
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                lock,
    output logic                dcm_rst,
    output logic [N_STAGES-1:0] rst_out,
    output logic                ready,
    output logic [3:0]          retries
);

    // One shared cycle counter serves DCMRST length, WAITLOCK timeout and the
    // STAGE spacing, so it is sized for the largest of the three.
    localparam int MAX_AB  = (DCM_RST_CYC > STAGE_DLY) ? DCM_RST_CYC : STAGE_DLY;
    localparam int CNT_MAX = (LOCK_TIMEOUT > MAX_AB) ? LOCK_TIMEOUT : MAX_AB;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int SW      = $clog2(LOCK_STABLE + 1);

    // Counters compare against "limit - 1" so the transition happens on the
    // edge where the count would reach the limit.
    localparam logic [CW-1:0] DCM_LAST    = CW'(DCM_RST_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STG_LAST    = CW'(STAGE_DLY - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);

    typedef enum logic [1:0] {
        ST_DCMRST   = 2'd0,
        ST_WAITLOCK = 2'd1,
        ST_STAGE    = 2'd2,
        ST_RUN      = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] stable_cnt;
    logic          lock_meta;
    logic          lock_s;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state      <= ST_DCMRST;
            cnt        <= '0;
            stable_cnt <= '0;
            lock_meta  <= 1'b0;
            lock_s     <= 1'b0;
            dcm_rst    <= 1'b1;
            rst_out    <= '1;
            ready      <= 1'b0;
            retries    <= 4'd0;
        end else begin
            lock_meta <= lock;
            lock_s    <= lock_meta;

            case (state)
                ST_DCMRST: begin
                    dcm_rst <= 1'b1;
                    rst_out <= '1;
                    ready   <= 1'b0;
                    if (cnt == DCM_LAST) begin
                        dcm_rst    <= 1'b0;
                        cnt        <= '0;
                        stable_cnt <= '0;
                        state      <= ST_WAITLOCK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_WAITLOCK: begin
                    // A stable lock wins over a timeout landing on the same edge.
                    if (lock_s && stable_cnt == STABLE_LAST) begin
                        cnt        <= '0;
                        stable_cnt <= '0;
                        state      <= ST_STAGE;
                    end else if (cnt == TMO_LAST) begin
                        cnt        <= '0;
                        stable_cnt <= '0;
                        dcm_rst    <= 1'b1;
                        state      <= ST_DCMRST;
                        if (retries != 4'd15) retries <= retries + 4'd1;
                    end else begin
                        cnt        <= cnt + CW'(1);
                        stable_cnt <= lock_s ? stable_cnt + SW'(1) : '0;
                    end
                end

                ST_STAGE: begin
                    if (!lock_s) begin
                        rst_out    <= '1;
                        ready      <= 1'b0;
                        dcm_rst    <= 1'b1;
                        cnt        <= '0;
                        stable_cnt <= '0;
                        state      <= ST_DCMRST;
                    end else if (rst_out == '0) begin
                        ready <= 1'b1;
                        state <= ST_RUN;
                    end else if (cnt == STG_LAST) begin
                        // Bits release strictly in index order, so the set bits
                        // are always a contiguous top block; shifting left
                        // clears the lowest one still set.
                        rst_out <= rst_out << 1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_RUN: begin
                    if (!lock_s) begin
                        rst_out    <= '1;
                        ready      <= 1'b0;
                        dcm_rst    <= 1'b1;
                        cnt        <= '0;
                        stable_cnt <= '0;
                        state      <= ST_DCMRST;
                    end
                end

                default: begin
                    rst_out    <= '1;
                    ready      <= 1'b0;
                    dcm_rst    <= 1'b1;
                    cnt        <= '0;
                    stable_cnt <= '0;
                    state      <= ST_DCMRST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_clk_rst_seq
//
// Directed bench for clk_rst_seq with N_STAGES=3, DCM_RST_CYC=4, LOCK_STABLE=4,
// LOCK_TIMEOUT=32, STAGE_DLY=8. Edge numbers count rising clk edges after rst_
// is released; outputs are sampled 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_clk_rst_seq;

    logic       clk = 1'b0;
    logic       rst_;
    logic       lock;
    logic       dcm_rst;
    logic [2:0] rst_out;
    logic       ready;
    logic [3:0] retries;

    int n_pass  = 0;
    int n_total = 0;
    int edge_n  = 0;

    typedef struct {
        int         at;
        logic       lock_nxt;
        logic       dcm;
        logic [2:0] ro;
        logic       rdy;
        logic [3:0] rt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    clk_rst_seq #(
        .N_STAGES    (3),
        .DCM_RST_CYC (4),
        .LOCK_STABLE (4),
        .LOCK_TIMEOUT(32),
        .STAGE_DLY   (8)
    ) dut (
        .clk    (clk),
        .rst_   (rst_),
        .lock   (lock),
        .dcm_rst(dcm_rst),
        .rst_out(rst_out),
        .ready  (ready),
        .retries(retries)
    );

    task automatic check(input string name, input logic e_dcm, input logic [2:0] e_ro,
                         input logic e_rdy, input logic [3:0] e_rt);
        n_total++;
        if (dcm_rst === e_dcm && rst_out === e_ro && ready === e_rdy && retries === e_rt)
            n_pass++;
        else
            $display("FAIL %s: got dcm_rst=%b rst_out=%b ready=%b retries=%0d, expected dcm_rst=%b rst_out=%b ready=%b retries=%0d",
                     name, dcm_rst, rst_out, ready, retries, e_dcm, e_ro, e_rdy, e_rt);
    endtask

    // Advance to the given edge number; returns 1 time unit after that edge.
    task automatic goto(input int target);
        while (edge_n < target) begin
            @(posedge clk);
            #1;
            edge_n++;
        end
    endtask

    // Hold reset for a couple of edges, check reset values, then release so
    // that the next rising edge is edge 1.
    task automatic start(input logic lk);
        rst_ = 1'b0;
        lock = lk;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 1'b1, 3'b111, 1'b0, 4'd0);
        rst_   = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        rst_ = 1'b0;
        lock = 1'b0;

        // Normal bring-up, lock drop in RUN at edge 50, re-lock after edge 53.
        vecs.push_back('{3,  1'b1, 1'b1, 3'b111, 1'b0, 4'd0});
        vecs.push_back('{4,  1'b1, 1'b0, 3'b111, 1'b0, 4'd0});
        vecs.push_back('{15, 1'b1, 1'b0, 3'b111, 1'b0, 4'd0});
        vecs.push_back('{16, 1'b1, 1'b0, 3'b110, 1'b0, 4'd0});
        vecs.push_back('{23, 1'b1, 1'b0, 3'b110, 1'b0, 4'd0});
        vecs.push_back('{24, 1'b1, 1'b0, 3'b100, 1'b0, 4'd0});
        vecs.push_back('{31, 1'b1, 1'b0, 3'b100, 1'b0, 4'd0});
        vecs.push_back('{32, 1'b1, 1'b0, 3'b000, 1'b0, 4'd0});
        vecs.push_back('{33, 1'b1, 1'b0, 3'b000, 1'b1, 4'd0});
        vecs.push_back('{50, 1'b0, 1'b0, 3'b000, 1'b1, 4'd0});
        vecs.push_back('{52, 1'b0, 1'b0, 3'b000, 1'b1, 4'd0});
        vecs.push_back('{53, 1'b1, 1'b1, 3'b111, 1'b0, 4'd0});
        vecs.push_back('{56, 1'b1, 1'b1, 3'b111, 1'b0, 4'd0});
        vecs.push_back('{57, 1'b1, 1'b0, 3'b111, 1'b0, 4'd0});
        vecs.push_back('{68, 1'b1, 1'b0, 3'b111, 1'b0, 4'd0});
        vecs.push_back('{69, 1'b1, 1'b0, 3'b110, 1'b0, 4'd0});
        vecs.push_back('{77, 1'b1, 1'b0, 3'b100, 1'b0, 4'd0});
        vecs.push_back('{85, 1'b1, 1'b0, 3'b000, 1'b0, 4'd0});
        vecs.push_back('{86, 1'b1, 1'b0, 3'b000, 1'b1, 4'd0});

        start(1'b1);
        foreach (vecs[i]) begin
            goto(vecs[i].at);
            check($sformatf("bringup@%0d", vecs[i].at), vecs[i].dcm, vecs[i].ro,
                  vecs[i].rdy, vecs[i].rt);
            lock = vecs[i].lock_nxt;
        end

        // Lock drop mid-STAGE after bit 0 released: all bits reassert together.
        start(1'b1);
        goto(16); check("midstage_b0", 1'b0, 3'b110, 1'b0, 4'd0);
        goto(17); lock = 1'b0;
        goto(19); check("midstage_pre", 1'b0, 3'b110, 1'b0, 4'd0);
        goto(20); check("midstage_drop", 1'b1, 3'b111, 1'b0, 4'd0);
        lock = 1'b1;
        goto(23); check("midstage_dcm_hold", 1'b1, 3'b111, 1'b0, 4'd0);
        goto(24); check("midstage_dcm_rel", 1'b0, 3'b111, 1'b0, 4'd0);
        goto(35); check("midstage_restage_pre", 1'b0, 3'b111, 1'b0, 4'd0);
        goto(36); check("midstage_restage_b0", 1'b0, 3'b110, 1'b0, 4'd0);

        // Glitchy lock: sampled high at edges 6-8, low at 9, high from 10.
        start(1'b0);
        goto(5);  lock = 1'b1;
        goto(8);  lock = 1'b0;
        goto(9);  lock = 1'b1;
        goto(11); check("glitch_e11", 1'b0, 3'b111, 1'b0, 4'd0);
        goto(19); check("glitch_no_early", 1'b0, 3'b111, 1'b0, 4'd0);
        goto(22); check("glitch_e22", 1'b0, 3'b111, 1'b0, 4'd0);
        goto(23); check("glitch_b0", 1'b0, 3'b110, 1'b0, 4'd0);

        // Lock never asserts: timeouts every 36 edges, retries saturates.
        start(1'b0);
        goto(3);   check("tmo_dcm_e3", 1'b1, 3'b111, 1'b0, 4'd0);
        goto(4);   check("tmo_dcm_e4", 1'b0, 3'b111, 1'b0, 4'd0);
        goto(35);  check("tmo_e35", 1'b0, 3'b111, 1'b0, 4'd0);
        goto(36);  check("tmo_first", 1'b1, 3'b111, 1'b0, 4'd1);
        goto(39);  check("tmo_dcm_hold", 1'b1, 3'b111, 1'b0, 4'd1);
        goto(40);  check("tmo_dcm_rel", 1'b0, 3'b111, 1'b0, 4'd1);
        goto(72);  check("tmo_second", 1'b1, 3'b111, 1'b0, 4'd2);
        goto(539); check("tmo_e539", 1'b0, 3'b111, 1'b0, 4'd14);
        goto(540); check("tmo_15th", 1'b1, 3'b111, 1'b0, 4'd15);
        goto(576); check("tmo_16th_sat", 1'b1, 3'b111, 1'b0, 4'd15);
        lock = 1'b1;
        goto(583); check("relock_pre", 1'b0, 3'b111, 1'b0, 4'd15);
        goto(592); check("relock_b0", 1'b0, 3'b110, 1'b0, 4'd15);
        goto(608); check("relock_b2", 1'b0, 3'b000, 1'b0, 4'd15);
        goto(609); check("relock_ready", 1'b0, 3'b000, 1'b1, 4'd15);

        // Asynchronous reset in RUN, between clock edges.
        goto(612);
        #3;
        rst_ = 1'b0;
        #1;
        check("async_rst", 1'b1, 3'b111, 1'b0, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
